// File: rtl/mips_regfile_pkg.sv
// Shared constants and types for the MIPS register file slice.
package mips_regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_RA   = 31;

  function automatic int idx_w(input int nregs);
    return $clog2(nregs);
  endfunction

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per GPR, set by a claim, cleared by late writeback.
module regfile_scoreboard
  import mips_regfile_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int IDX_W = idx_w(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*IDX_W-1:0] rd_idx,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 w1_en,
  input  logic [IDX_W-1:0]     w1_idx,
  input  logic                 claim_en,
  input  logic [IDX_W-1:0]     claim_idx,
  output logic                 claim_ok
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  assign claim_ok = ~pending_q[claim_idx] | (claim_idx == '0);

  // Clear first so a simultaneous claim of the same index leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (w1_en) pending_d[w1_idx] = 1'b0;
    if (claim_en && claim_ok && claim_idx != '0) pending_d[claim_idx] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_busy
    logic [IDX_W-1:0] idx;
    assign idx = rd_idx[gi*IDX_W +: IDX_W];
    if (BYPASS != 0) begin : g_byp
      // A late writeback landing this cycle resolves the hazard for the reader now.
      assign rd_busy[gi] = pending_q[idx] & ~(w1_en && w1_idx == idx);
    end else begin : g_nobyp
      assign rd_busy[gi] = pending_q[idx];
    end
  end

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS GPR file with two write ports, optional write-to-read bypass, scoreboard and HI/LO.
module mips_regfile_sb
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int IDX_W = idx_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*IDX_W-1:0]  rd_idx,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  w0_en,
  input  logic [IDX_W-1:0]      w0_idx,
  input  logic [DATA_W-1:0]     w0_data,
  input  logic                  w1_en,
  input  logic [IDX_W-1:0]      w1_idx,
  input  logic [DATA_W-1:0]     w1_data,
  input  logic                  claim_en,
  input  logic [IDX_W-1:0]      claim_idx,
  output logic                  claim_ok,
  input  logic                  hilo_we,
  input  logic [DATA_W-1:0]     hi_in,
  input  logic [DATA_W-1:0]     lo_in,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  // w1 applied last so it wins a same-index collision with w0.
  always_comb begin
    regs_d = regs_q;
    if (w0_en && w0_idx != '0) regs_d[w0_idx] = w0_data;
    if (w1_en && w1_idx != '0) regs_d[w1_idx] = w1_data;
    regs_d[0] = '0;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we) begin
      hi_d = hi_in;
      lo_d = lo_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      regs_q <= regs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    assign idx = rd_idx[gi*IDX_W +: IDX_W];
    always_comb begin
      data = regs_q[idx];
      if (BYPASS != 0) begin
        if (w0_en && w0_idx == idx) data = w0_data;
        if (w1_en && w1_idx == idx) data = w1_data;
      end
      if (idx == '0) data = '0;
    end
    assign rd_data[gi*DATA_W +: DATA_W] = data;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (rd_idx),
    .rd_busy   (rd_busy),
    .w1_en     (w1_en),
    .w1_idx    (w1_idx),
    .claim_en  (claim_en),
    .claim_idx (claim_idx),
    .claim_ok  (claim_ok)
  );

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Randomized + directed bench: bypass and non-bypass instances share stimulus, checked against a register/pending array model.
module tb_mips_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_idx;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        w0_en, w1_en, claim_en, hilo_we;
  logic [4:0]  w0_idx, w1_idx, claim_idx;
  logic [31:0] w0_data, w1_data, hi_in, lo_in;
  logic        claim_ok_a, claim_ok_b;
  logic [31:0] hi_a, lo_a, hi_b, lo_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mips_regfile_sb #(.DATA_W(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .w0_en(w0_en), .w0_idx(w0_idx), .w0_data(w0_data),
    .w1_en(w1_en), .w1_idx(w1_idx), .w1_data(w1_data),
    .claim_en(claim_en), .claim_idx(claim_idx), .claim_ok(claim_ok_a),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_a), .lo_out(lo_a));

  mips_regfile_sb #(.DATA_W(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .w0_en(w0_en), .w0_idx(w0_idx), .w0_data(w0_data),
    .w1_en(w1_en), .w1_idx(w1_idx), .w1_data(w1_data),
    .claim_en(claim_en), .claim_idx(claim_idx), .claim_ok(claim_ok_b),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_b), .lo_out(lo_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
    if (idx == 0) return 32'h0;
    if (byp && w1_en && w1_idx == idx) return w1_data;
    if (byp && w0_en && w0_idx == idx) return w0_data;
    return m_regs[idx];
  endfunction

  function automatic bit exp_busy(input logic [4:0] idx, input bit byp);
    if (byp && w1_en && w1_idx == idx) return 1'b0;
    return m_pend[idx];
  endfunction

  task automatic idle();
    reset = 0; rd_idx = '0; hilo_we = 0; hi_in = '0; lo_in = '0;
    w0_en = 0; w0_idx = '0; w0_data = '0;
    w1_en = 0; w1_idx = '0; w1_data = '0;
    claim_en = 0; claim_idx = '0;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    rd_idx = {p1, p0};
  endtask

  // Compare every output of both instances with the model under current inputs.
  task automatic settle_check();
    logic [4:0] idx;
    #1;
    for (int p = 0; p < 2; p++) begin
      idx = rd_idx[p*5 +: 5];
      check_eq("rd_data_byp",   rd_data_a[p*32 +: 32], exp_rd(idx, 1'b1));
      check_eq("rd_data_nobyp", rd_data_b[p*32 +: 32], exp_rd(idx, 1'b0));
      check_eq("rd_busy_byp",   32'(rd_busy_a[p]), 32'(exp_busy(idx, 1'b1)));
      check_eq("rd_busy_nobyp", 32'(rd_busy_b[p]), 32'(exp_busy(idx, 1'b0)));
    end
    check_eq("claim_ok_byp",   32'(claim_ok_a), 32'(claim_idx == 0 || !m_pend[claim_idx]));
    check_eq("claim_ok_nobyp", 32'(claim_ok_b), 32'(claim_idx == 0 || !m_pend[claim_idx]));
    check_eq("hi_byp",   hi_a, m_hi);
    check_eq("lo_byp",   lo_a, m_lo);
    check_eq("hi_nobyp", hi_b, m_hi);
    check_eq("lo_nobyp", lo_b, m_lo);
  endtask

  task automatic tick();
    bit ok;
    ok = (claim_idx == 0) || !m_pend[claim_idx];
    $display("[TB] cyc %0d rst=%0b w0=%0b/%0d/%08h w1=%0b/%0d/%08h claim=%0b/%0d rd=%0d,%0d",
             cyc, reset, w0_en, w0_idx, w0_data, w1_en, w1_idx, w1_data,
             claim_en, claim_idx, rd_idx[4:0], rd_idx[9:5]);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      m_hi = '0; m_lo = '0;
    end else begin
      if (w0_en && w0_idx != 0) m_regs[w0_idx] = w0_data;
      if (w1_en && w1_idx != 0) m_regs[w1_idx] = w1_data;
      if (w1_en) m_pend[w1_idx] = 0;
      if (claim_en && ok && claim_idx != 0) m_pend[claim_idx] = 1;
      if (hilo_we) begin m_hi = hi_in; m_lo = lo_in; end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();

    // 1: basic write then read
    idle(); w0_en = 1; w0_idx = 5; w0_data = 32'hDEADBEEF; settle_check(); tick();
    idle(); set_rd(5, 0); settle_check();
    check_eq("t1_rd5", rd_data_a[31:0], 32'hDEADBEEF);
    check_eq("t1_busy5", 32'(rd_busy_a[0]), 32'h0);
    tick();

    // 2: register 0 is immutable and unclaimable
    idle(); w0_en = 1; w0_idx = 0; w0_data = 32'h12345678; claim_en = 1; claim_idx = 0;
    settle_check();
    check_eq("t2_rd0_bypass", rd_data_a[31:0], 32'h0);
    check_eq("t2_claim0_ok", 32'(claim_ok_a), 32'h1);
    tick();
    idle(); settle_check();
    check_eq("t2_rd0_p1", rd_data_a[63:32], 32'h0);
    check_eq("t2_busy0", 32'({rd_busy_a, rd_busy_b}), 32'h0);
    tick();

    // 3: same-cycle bypass vs registered read
    idle(); w0_en = 1; w0_idx = 7; w0_data = 32'hA5A5A5A5; set_rd(0, 7); settle_check();
    check_eq("t3_byp", rd_data_a[63:32], 32'hA5A5A5A5);
    check_eq("t3_nobyp_old", rd_data_b[63:32], 32'h0);
    tick();
    idle(); set_rd(0, 7); settle_check();
    check_eq("t3_nobyp_new", rd_data_b[63:32], 32'hA5A5A5A5);
    tick();

    // 4: claim, WAW stall, late writeback resolves
    idle(); claim_en = 1; claim_idx = 9; settle_check();
    check_eq("t4_claim_ok", 32'(claim_ok_a), 32'h1);
    tick();
    idle(); set_rd(9, 0); claim_en = 1; claim_idx = 9; settle_check();
    check_eq("t4_busy", 32'(rd_busy_a[0]), 32'h1);
    check_eq("t4_waw", 32'(claim_ok_a), 32'h0);
    tick();
    idle(); set_rd(9, 0); w1_en = 1; w1_idx = 9; w1_data = 32'h55; settle_check();
    check_eq("t4_busy_byp", 32'(rd_busy_a[0]), 32'h0);
    check_eq("t4_busy_nobyp", 32'(rd_busy_b[0]), 32'h1);
    check_eq("t4_data", rd_data_a[31:0], 32'h55);
    tick();
    idle(); set_rd(9, 0); settle_check();
    check_eq("t4_cleared", 32'(rd_busy_b[0]), 32'h0);
    tick();

    // 5: claim + w1 same index (set wins); w0/w1 collision (w1 wins)
    idle(); claim_en = 1; claim_idx = 3; w1_en = 1; w1_idx = 3; w1_data = 32'h33; settle_check(); tick();
    idle(); set_rd(3, 0); settle_check();
    check_eq("t5_pend_kept", 32'(rd_busy_b[0]), 32'h1);
    check_eq("t5_r3", rd_data_b[31:0], 32'h33);
    tick();
    idle(); w0_en = 1; w0_idx = 4; w0_data = 1; w1_en = 1; w1_idx = 4; w1_data = 2; set_rd(4, 4);
    settle_check();
    check_eq("t5_fwd_w1", rd_data_a[31:0], 32'h2);
    tick();
    idle(); set_rd(4, 3); settle_check();
    check_eq("t5_r4", rd_data_b[31:0], 32'h2);
    tick();

    // 6: reset mid-operation
    idle(); claim_en = 1; claim_idx = 10; w1_en = 1; w1_idx = 11; w1_data = 32'h99;
    hilo_we = 1; hi_in = 1; lo_in = 2; settle_check(); tick();
    idle(); set_rd(10, 11); settle_check();
    check_eq("t6_hi_pre", hi_a, 32'h1);
    check_eq("t6_lo_pre", lo_a, 32'h2);
    reset = 1; tick();
    idle(); set_rd(10, 11); claim_idx = 10; settle_check();
    check_eq("t6_r11", rd_data_a[63:32], 32'h0);
    check_eq("t6_busy", 32'({rd_busy_a, rd_busy_b}), 32'h0);
    check_eq("t6_claim_ok", 32'(claim_ok_a), 32'h1);
    check_eq("t6_hi", hi_a, 32'h0);
    check_eq("t6_lo", lo_a, 32'h0);
    tick();
    idle(); w1_en = 1; w1_idx = 10; w1_data = 32'h77; settle_check(); tick();
    idle(); set_rd(10, 0); settle_check();
    check_eq("t6_w1_unclaimed", rd_data_b[31:0], 32'h77);
    tick();

    // Random phase: narrow index range to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      idle();
      reset     = ($urandom_range(0, 99) < 2);
      set_rd(5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
      w0_en     = $urandom_range(0, 1);
      w0_idx    = 5'($urandom_range(0, 11));
      w0_data   = $urandom;
      w1_en     = ($urandom_range(0, 2) == 0);
      w1_idx    = 5'($urandom_range(0, 11));
      w1_data   = $urandom;
      claim_en  = ($urandom_range(0, 2) == 0);
      claim_idx = 5'($urandom_range(0, 11));
      hilo_we   = ($urandom_range(0, 4) == 0);
      hi_in     = $urandom;
      lo_in     = $urandom;
      if ($urandom_range(0, 9) == 0) set_rd(5'($urandom), 5'($urandom));
      settle_check();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
